id_ex_stage: RTL

- ID/EX pipeline register of the Mini-RISC-V core, with load-use hazard detection and bubble/flush control.
- Captures decoded operands and control from ID each cycle.
- Presents the registered ID_EX_* values consumed by the EX-stage forwarding unit and ALU.
- Stalls ID/IF for exactly one cycle when an instruction in ID depends on a load currently in EX.

---
 rtl/core_pkg.sv | 20 ++
 rtl/sat_counter.sv | 20 ++
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the Mini-RISC-V pipeline.
// The ID/EX control bundle is packed so that a bubble is simply the all-zero value.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic       valid;
        logic       alusrc;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       csr_read;
        logic [3:0] alu_ctrl;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Event counter that increments on inc and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         Rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and flush control.
// A flush seen while the pipeline is held is remembered and applied on the first free edge.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              hold,
    input  logic              ex_flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_alusrc,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_csr_read,
    input  logic [3:0]        id_alu_ctrl,
    output logic              ID_EX_valid,
    output logic              ID_EX_alusrc,
    output logic              ID_EX_regwrite,
    output logic              ID_EX_memread,
    output logic              ID_EX_memwrite,
    output logic              ID_EX_csr_read,
    output logic [XLEN-1:0]   ID_EX_pc,
    output logic [XLEN-1:0]   ID_EX_rs1_data,
    output logic [XLEN-1:0]   ID_EX_rs2_data,
    output logic [XLEN-1:0]   ID_EX_imm,
    output logic [REG_AW-1:0] ID_EX_rs1,
    output logic [REG_AW-1:0] ID_EX_rs2,
    output logic [REG_AW-1:0] ID_EX_rd,
    output logic [3:0]        ID_EX_alu_ctrl,
    output logic              id_stall,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    id_ex_ctrl_t       ctrl_q;
    id_ex_ctrl_t       ctrl_d;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   rs1_data_q;
    logic [XLEN-1:0]   rs2_data_q;
    logic [XLEN-1:0]   imm_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [REG_AW-1:0] rd_q;
    logic              flush_pending;
    logic              haz;
    logic              kill;
    logic              rs1_match;
    logic              rs2_match;

    // A load in EX blocks any ID instruction that actually reads its destination (x0 never counts).
    assign rs1_match = id_uses_rs1 && (id_rs1 == rd_q);
    assign rs2_match = id_uses_rs2 && (id_rs2 == rd_q);
    assign haz       = ctrl_q.valid && ctrl_q.memread && (rd_q != '0) && id_valid
                       && (rs1_match || rs2_match);
    assign kill      = ex_flush || flush_pending;
    assign id_stall  = haz && !kill;

    always_comb begin
        ctrl_d          = ID_EX_BUBBLE;
        ctrl_d.valid    = id_valid;
        ctrl_d.alusrc   = id_alusrc;
        ctrl_d.regwrite = id_regwrite;
        ctrl_d.memread  = id_memread;
        ctrl_d.memwrite = id_memwrite;
        ctrl_d.csr_read = id_csr_read;
        ctrl_d.alu_ctrl = id_alu_ctrl;
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            ctrl_q        <= ID_EX_BUBBLE;
            pc_q          <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            flush_pending <= 1'b0;
        end else if (hold) begin
            if (ex_flush) begin
                flush_pending <= 1'b1;
            end
        end else if (kill || haz) begin
            // Bubbles carry rd=0 and regwrite=0 so forwarding never matches them.
            ctrl_q        <= ID_EX_BUBBLE;
            pc_q          <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            flush_pending <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            pc_q          <= id_pc;
            rs1_data_q    <= id_rs1_data;
            rs2_data_q    <= id_rs2_data;
            imm_q         <= id_imm;
            rs1_q         <= id_rs1;
            rs2_q         <= id_rs2;
            rd_q          <= id_rd;
        end
    end

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .Rst   (Rst),
        .inc   (!hold && !kill && haz),
        .count (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .Rst   (Rst),
        .inc   (!hold && kill),
        .count (flush_cnt)
    );

    assign ID_EX_valid    = ctrl_q.valid;
    assign ID_EX_alusrc   = ctrl_q.alusrc;
    assign ID_EX_regwrite = ctrl_q.regwrite;
    assign ID_EX_memread  = ctrl_q.memread;
    assign ID_EX_memwrite = ctrl_q.memwrite;
    assign ID_EX_csr_read = ctrl_q.csr_read;
    assign ID_EX_alu_ctrl = ctrl_q.alu_ctrl;
    assign ID_EX_pc       = pc_q;
    assign ID_EX_rs1_data = rs1_data_q;
    assign ID_EX_rs2_data = rs2_data_q;
    assign ID_EX_imm      = imm_q;
    assign ID_EX_rs1      = rs1_q;
    assign ID_EX_rs2      = rs2_q;
    assign ID_EX_rd       = rd_q;

endmodule
